// File: rtl/spike_event_encoder.sv
// spike_event_encoder
//   Turns a time-multiplexed stream of neuron membrane updates into a queue of
//   spike events (neuron id + timestep). A sample registered in the detect
//   stage is written into the event FIFO one cycle after it is accepted.
//
// Optional feature (macro SPIKE_EDGE_DETECT_EN):
//   defined   - emit only on a rising threshold crossing, using a per-neuron
//               above-threshold bit
//   undefined - emit on every accepted above-threshold sample; no bit array
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous reset, active low
//   in_valid   in   neuron result present (no back-pressure)
//   in_id      in   neuron index; ids >= NEURON_COUNT are ignored
//   in_v       in   signed membrane value
//   out_valid  out  event at FIFO head
//   out_ready  in   consumer takes the head event
//   out_id     out  head event neuron index
//   out_ts     out  head event timestep
//   timestep   out  current sweep number
//   fifo_count out  FIFO occupancy
//   overflow   out  sticky, set when an event is dropped on a full FIFO
//   clr_ovf    in   synchronous clear of overflow (a same-cycle drop wins)

module spike_event_encoder #(
  parameter int                            NEURON_COUNT = 500,
  parameter int                            DATA_WIDTH   = 16,
  parameter logic signed [DATA_WIDTH-1:0]  V_THRESH     = 16'sh0800,
  parameter int                            FIFO_DEPTH   = 16,
  parameter int                            TS_WIDTH     = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic [$clog2(NEURON_COUNT)-1:0]   in_id,
  input  logic signed [DATA_WIDTH-1:0]      in_v,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [$clog2(NEURON_COUNT)-1:0]   out_id,
  output logic [TS_WIDTH-1:0]               out_ts,
  output logic [TS_WIDTH-1:0]               timestep,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_count,
  output logic                              overflow,
  input  logic                              clr_ovf
);

  localparam int ID_W   = $clog2(NEURON_COUNT);
  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NEURON_COUNT - 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic accept;
  logic above_thr;
  logic spike;

  assign accept    = in_valid && (in_id <= LAST_ID);
  assign above_thr = (in_v >= V_THRESH);

`ifdef SPIKE_EDGE_DETECT_EN
  logic [NEURON_COUNT-1:0] above_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      above_q <= '0;
    end else if (accept) begin
      above_q[in_id] <= above_thr;
    end
  end

  assign spike = above_thr && !above_q[in_id];
`else
  assign spike = above_thr;
`endif

  // Detect stage. The event is tagged with the timestep before the
  // increment its own sample may cause (last neuron of the sweep).
  logic                det_valid;
  logic [ID_W-1:0]     det_id;
  logic [TS_WIDTH-1:0] det_ts;
  logic [TS_WIDTH-1:0] ts_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      det_valid <= 1'b0;
      det_id    <= '0;
      det_ts    <= '0;
      ts_q      <= '0;
    end else begin
      det_valid <= accept && spike;
      if (accept) begin
        det_id <= in_id;
        det_ts <= ts_q;
        if (in_id == LAST_ID) begin
          ts_q <= ts_q + TS_WIDTH'(1);
        end
      end
    end
  end

  // Event FIFO. When full, a push is only admitted alongside a pop; the
  // write slot then equals the head slot being vacated on the same edge.
  logic [ID_W-1:0]     mem_id [FIFO_DEPTH];
  logic [TS_WIDTH-1:0] mem_ts [FIFO_DEPTH];
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]    count_q;
  logic                full;
  logic                pop;
  logic                push;
  logic                drop;
  logic                ovf_q;

  assign out_valid = (count_q != '0);
  assign full      = (count_q == DEPTH_C);
  assign pop       = out_valid && out_ready;
  assign push      = det_valid && (!full || pop);
  assign drop      = det_valid && full && !pop;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_id[wr_ptr] <= det_id;
      mem_ts[wr_ptr] <= det_ts;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (clr_ovf) begin
        ovf_q <= 1'b0;
      end
    end
  end

  // Memory is not reset; gating keeps the head outputs at zero when empty.
  assign out_id     = out_valid ? mem_id[rd_ptr] : '0;
  assign out_ts     = out_valid ? mem_ts[rd_ptr] : '0;
  assign timestep   = ts_q;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_spike_event_encoder.sv
// tb_spike_event_encoder
//   Randomized and directed stimulus for spike_event_encoder, checked every
//   cycle against a queue-based reference model of the event stream.

module tb_spike_event_encoder;

  localparam int NC = 500;
  localparam int FD = 16;
  localparam logic signed [15:0] THR = 16'sh0800;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic [8:0]         in_id;
  logic signed [15:0] in_v;
  logic               out_valid;
  logic               out_ready;
  logic [8:0]         out_id;
  logic [15:0]        out_ts;
  logic [15:0]        timestep;
  logic [4:0]         fifo_count;
  logic               overflow;
  logic               clr_ovf;

  spike_event_encoder dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_id      (in_id),
    .in_v       (in_v),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_id     (out_id),
    .out_ts     (out_ts),
    .timestep   (timestep),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: events are {id, ts}; pend is the event produced by the
  // sample accepted on the previous edge, entering the queue on the next one.
  logic [24:0] q[$];
  logic [24:0] got_q[$];
  bit          above_m[NC];
  logic [15:0] ts_m;
  bit          pend_v;
  logic [24:0] pend_e;
  bit          ovf_m;

  task automatic model_reset();
    q.delete();
    ts_m   = '0;
    pend_v = 1'b0;
    pend_e = '0;
    ovf_m  = 1'b0;
    for (int i = 0; i < NC; i++) above_m[i] = 1'b0;
  endtask

  task automatic step();
    bit pop_m, drop_m, acc, sp;
    logic [24:0] e;
    if (out_valid && out_ready) got_q.push_back({out_id, out_ts});
    pop_m  = (q.size() != 0) && out_ready;
    drop_m = pend_v && (q.size() == FD) && !pop_m;
    if (pop_m) void'(q.pop_front());
    if (pend_v && !drop_m) q.push_back(pend_e);
    if (drop_m) ovf_m = 1'b1;
    else if (clr_ovf) ovf_m = 1'b0;
    acc = in_valid && (int'(in_id) < NC);
    pend_v = 1'b0;
    if (acc) begin
      sp = (in_v >= THR);
`ifdef SPIKE_EDGE_DETECT_EN
      if (above_m[in_id]) sp = 1'b0;
      above_m[in_id] = (in_v >= THR);
`endif
      pend_v = sp;
      pend_e = {in_id, ts_m};
      if (int'(in_id) == NC - 1) ts_m = ts_m + 16'd1;
    end
    @(posedge clk);
    #1;
    check("out_valid", out_valid, q.size() != 0);
    check("fifo_count", fifo_count, q.size());
    check("timestep", timestep, ts_m);
    check("overflow", overflow, ovf_m);
    if (q.size() != 0) begin
      e = q[0];
      check("out_id", out_id, e[24:16]);
      check("out_ts", out_ts, e[15:0]);
    end else begin
      check("out_id_empty", out_id, 0);
    end
  endtask

  task automatic sample(input int id, input logic signed [15:0] v);
    in_valid = 1'b1;
    in_id    = 9'(id);
    in_v     = v;
    step();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic sweep(input int lo, input int hi, input logic signed [15:0] vh,
                       input logic signed [15:0] vl);
    for (int id = 0; id < NC; id++) sample(id, (id >= lo && id <= hi) ? vh : vl);
  endtask

  logic [24:0] g;

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_id = '0; in_v = '0;
    out_ready = 1'b0; clr_ovf = 1'b0;
    model_reset();
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_timestep", timestep, 0);
    check("rst_overflow", overflow, 0);
    check("rst_out_id", out_id, 0);
    check("rst_out_ts", out_ts, 0);
    @(negedge clk);
    rst = 1'b1;

    // Single spike at exactly the threshold, two-cycle latency
    out_ready = 1'b1;
    sample(7, 16'sh0800);
    check("lat_n1_valid", out_valid, 0);
    idle(1);
    check("lat_n2_valid", out_valid, 1);
    check("lat_id", out_id, 7);
    check("lat_ts", out_ts, 0);
    idle(1);
    check("lat_drained", fifo_count, 0);

    // Just below threshold: no event
    sample(3, 16'sh07FF);
    idle(3);

    // Full sub-threshold sweep advances the timestep only
    sweep(1, 0, 16'sh0000, 16'shECE1);
    idle(3);
    check("sweep_ts", timestep, 1);

    // id 7 above threshold in two consecutive sweeps
    got_q.delete();
    sweep(7, 7, 16'sh1000, 16'shECE1);
    sweep(7, 7, 16'sh1000, 16'shECE1);
    idle(4);
`ifdef SPIKE_EDGE_DETECT_EN
    check("two_sweep_events", got_q.size(), 1);
`else
    check("two_sweep_events", got_q.size(), 2);
`endif

    // 17 spikes with the consumer stalled: 16 kept, one dropped
    sweep(1, 0, 16'sh0000, 16'shECE1);
    idle(2);
    out_ready = 1'b0;
    sweep(0, 16, 16'sh0900, 16'shECE1);
    idle(2);
    check("ovf_count", fifo_count, 16);
    check("ovf_flag", overflow, 1);
    got_q.delete();
    out_ready = 1'b1;
    clr_ovf = 1'b1;
    idle(1);
    clr_ovf = 1'b0;
    idle(20);
    check("drain_size", got_q.size(), 16);
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      g = got_q[i];
      check("drain_order", g[24:16], i);
    end

    // Full FIFO: push and pop in the same cycle both succeed
    for (int i = 0; i <= 20; i++) sample(i, 16'sh0100);
    idle(2);
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) sample(i, 16'sh0900);
    sample(20, 16'sh0900);
    check("full_before", fifo_count, 16);
    got_q.delete();
    out_ready = 1'b1;
    idle(1);
    check("full_pushpop_count", fifo_count, 16);
    check("full_pushpop_ovf", overflow, 0);
    idle(20);
    check("full_drain_size", got_q.size(), 17);
    if (got_q.size() != 0) begin
      g = got_q[got_q.size() - 1];
      check("full_last_id", g[24:16], 20);
    end

    // Out-of-range ids are ignored
    sample(500, 16'sh7FFF);
    sample(511, 16'sh7FFF);
    idle(3);
    check("oor_count", fifo_count, 0);

    // Randomized traffic with varying consumer rate and overflow clears
    for (int blk = 0; blk < 6; blk++) begin
      int rdy_pct;
      rdy_pct = (blk % 2 == 0) ? 15 : 85;
      for (int c = 0; c < 600; c++) begin
        int r;
        in_valid  = ($urandom_range(0, 3) != 0);
        r = $urandom_range(0, 19);
        in_id     = (r == 0) ? 9'($urandom_range(500, 511)) :
                    (r == 1) ? 9'(NC - 1) : 9'($urandom_range(0, 30));
        r = $urandom_range(0, 3);
        in_v      = (r == 0) ? THR : (r == 1) ? 16'sh07FF : 16'($urandom);
        out_ready = ($urandom_range(0, 99) < rdy_pct);
        clr_ovf   = ($urandom_range(0, 31) == 0);
        step();
      end
    end
    in_valid = 1'b0; clr_ovf = 1'b0;
    out_ready = 1'b1;
    idle(20);

    // Asynchronous reset with events queued
    for (int i = 0; i < 5; i++) sample(i, 16'sh0100);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) sample(i, 16'sh0900);
    idle(2);
    check("pre_rst_count", fifo_count, 5);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_fifo_count", fifo_count, 0);
    check("async_timestep", timestep, 0);
    check("async_overflow", overflow, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    sample(3, 16'sh0900);
    idle(1);
    check("post_rst_valid", out_valid, 1);
    check("post_rst_id", out_id, 3);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
